// File: rtl/axi4lite_read_if.sv
// rtl/axi4lite_read_if.sv - AXI4-Lite read address and read data channels
interface axi4lite_read_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4lite_read.sv
// rtl/axi4lite_read.sv - AXI4-Lite read slave bridging one read at a time to a register file
module axi4lite_read #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  aresetb,
  axi4lite_read_if.slave        axi,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  valid,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_data_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic [7:0]            cnt_q, cnt_d;

  logic unused_arprot;
  assign unused_arprot = ^axi.arprot;

  always_ff @(posedge clk or negedge aresetb) begin
    if (!aresetb) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    addr_d    = addr_q;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        // arready comes up one edge after reset release, then stays up in IDLE
        arready_d = 1'b1;
        if (axi.arvalid && arready_q) begin
          addr_d    = axi.araddr;
          arready_d = 1'b0;
          valid_d   = 1'b1;
          cnt_d     = 8'd0;
          state_d   = REQ;
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Data arriving on the final window cycle still wins over the timeout
        if (rd_data_valid) begin
          rdata_d  = rd_data;
          rresp_d  = RESP_OKAY;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (axi.rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign addr        = addr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_axi4lite_read.sv
// tb/tb_axi4lite_read.sv - directed table-driven bench for axi4lite_read
module tb_axi4lite_read;
  localparam int AW = 40;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          aresetb;
  logic [AW-1:0] addr;
  logic          valid;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;

  axi4lite_read_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

  axi4lite_read #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .aresetb      (aresetb),
    .axi          (axi),
    .addr         (addr),
    .valid        (valid),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;

  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            dv;
    int            hold;
    logic [DW-1:0] exp_d;
    logic [1:0]    exp_r;
    int            exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_read(input vec_t v);
    int k;
    int lat;
    int base;
    base = valid_cnt;
    k = 0;
    while (axi.arready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("arready_idle", 64'(axi.arready), 64'd1);
    axi.araddr  = v.a;
    axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    axi.araddr  = 40'h5A_5A5A_5A5A;
    check("valid_req", 64'(valid), 64'd1);
    check("addr_capture", 64'(addr), 64'(v.a));
    check("arready_busy", 64'(axi.arready), 64'd0);
    lat = 0;
    while (axi.rvalid !== 1'b1 && lat < TO + 4) begin
      rd_data_valid = (lat == v.dv);
      rd_data       = (lat == v.dv) ? v.d : DW'($urandom);
      @(negedge clk);
      lat++;
    end
    rd_data_valid = 1'b0;
    check("rvalid_latency", 64'(lat), 64'(v.exp_lat));
    check("rdata", 64'(axi.rdata), 64'(v.exp_d));
    check("rresp", 64'(axi.rresp), 64'(v.exp_r));
    for (int h = 0; h < v.hold; h++) begin
      rd_data_valid = 1'b1;
      rd_data       = DW'($urandom);
      axi.rready    = 1'b0;
      @(negedge clk);
      check("hold_rvalid", 64'(axi.rvalid), 64'd1);
      check("hold_rdata", 64'(axi.rdata), 64'(v.exp_d));
      check("hold_rresp", 64'(axi.rresp), 64'(v.exp_r));
      check("hold_arready", 64'(axi.arready), 64'd0);
    end
    rd_data_valid = 1'b0;
    axi.rready    = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check("rvalid_cleared", 64'(axi.rvalid), 64'd0);
    check("arready_after_r", 64'(axi.arready), 64'd1);
    check("valid_pulses", 64'(valid_cnt - base), 64'd1);
    check("addr_held", 64'(addr), 64'(v.a));
  endtask

  initial begin
    int lat;
    int base;
    vecs[0] = '{40'h14,           32'hA5A5_0001, 0,  0, 32'hA5A5_0001, 2'b00, 1};
    vecs[1] = '{40'h20,           32'h1234_5678, 5,  7, 32'h1234_5678, 2'b00, 6};
    vecs[2] = '{40'h30,           32'hDEAD_BEEF, -1, 2, 32'h0,         2'b10, 16};
    vecs[3] = '{40'h3C,           32'h0000_0003, 15, 0, 32'h0000_0003, 2'b00, 16};
    vecs[4] = '{40'hFF_FFFF_FFFC, 32'hFFFF_FFFF, 14, 1, 32'hFFFF_FFFF, 2'b00, 15};
    vecs[5] = '{40'h08,           32'h0000_0000, 1,  3, 32'h0000_0000, 2'b00, 2};

    aresetb       = 1'b0;
    axi.araddr    = '0;
    axi.arprot    = 3'b000;
    axi.arvalid   = 1'b0;
    axi.rready    = 1'b0;
    rd_data       = '0;
    rd_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_arready", 64'(axi.arready), 64'd0);
    check("rst_rvalid", 64'(axi.rvalid), 64'd0);
    check("rst_rdata", 64'(axi.rdata), 64'd0);
    check("rst_rresp", 64'(axi.rresp), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    aresetb = 1'b1;
    #1 check("arready_before_edge", 64'(axi.arready), 64'd0);
    @(negedge clk);
    check("arready_first_edge", 64'(axi.arready), 64'd1);

    axi.arprot = 3'b111;
    for (int i = 0; i < 6; i++) do_read(vecs[i]);

    // back-to-back with arvalid held high across the first transaction
    base = valid_cnt;
    axi.araddr  = 40'h40;
    axi.arvalid = 1'b1;
    @(negedge clk);
    check("b2b_addr0", 64'(addr), 64'h40);
    axi.araddr = 40'h44;
    lat = 0;
    while (axi.rvalid !== 1'b1 && lat < TO + 4) begin
      rd_data_valid = (lat == 2);
      rd_data       = 32'h4040_4040;
      @(negedge clk);
      lat++;
    end
    rd_data_valid = 1'b0;
    check("b2b_lat0", 64'(lat), 64'd3);
    check("b2b_rdata0", 64'(axi.rdata), 64'h4040_4040);
    check("b2b_addr_not_recaptured", 64'(addr), 64'h40);
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check("b2b_idle_addr", 64'(addr), 64'h40);
    check("b2b_idle_valid", 64'(valid), 64'd0);
    @(negedge clk);
    axi.arvalid = 1'b0;
    check("b2b_valid1", 64'(valid), 64'd1);
    check("b2b_addr1", 64'(addr), 64'h44);
    rd_data_valid = 1'b1;
    rd_data       = 32'h4444_4444;
    @(negedge clk);
    rd_data_valid = 1'b0;
    check("b2b_rvalid1", 64'(axi.rvalid), 64'd1);
    check("b2b_rdata1", 64'(axi.rdata), 64'h4444_4444);
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    check("b2b_valid_pulses", 64'(valid_cnt - base), 64'd2);

    // reset asserted while waiting on the register file
    axi.araddr  = 40'h50;
    axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_rvalid", 64'(axi.rvalid), 64'd0);
    aresetb       = 1'b0;
    rd_data_valid = 1'b1;
    rd_data       = 32'h7777_7777;
    #1;
    check("async_arready", 64'(axi.arready), 64'd0);
    check("async_addr", 64'(addr), 64'd0);
    @(negedge clk);
    check("rstw_rvalid", 64'(axi.rvalid), 64'd0);
    check("rstw_valid", 64'(valid), 64'd0);
    check("rstw_rdata", 64'(axi.rdata), 64'd0);
    check("rstw_arready", 64'(axi.arready), 64'd0);
    aresetb = 1'b1;
    @(negedge clk);
    check("rel_arready", 64'(axi.arready), 64'd1);
    check("rel_rvalid", 64'(axi.rvalid), 64'd0);
    @(negedge clk);
    check("late_rdv_ignored", 64'(axi.rvalid), 64'd0);
    rd_data_valid = 1'b0;
    do_read('{40'h60, 32'hCAFE_F00D, 3, 1, 32'hCAFE_F00D, 2'b00, 4});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
